// File: rtl/a2d_pkg.sv
// -----------------------------------------------------------------------------
// a2d_pkg
// Shared definitions for the ADC128S interface: ADC channel numbers for each
// sensor, the conversion sequencer state type, the SCLK divider width and a
// helper that builds the channel-select command word.
// -----------------------------------------------------------------------------
package a2d_pkg;

    // SCLK is the MSB of a free-running divider of this width (clk/32)
    localparam int SCLK_DIV_W = 5;

    // ADC128S input channels wired to each sensor
    localparam logic [2:0] CH_LFT   = 3'd0;
    localparam logic [2:0] CH_RGHT  = 3'd4;
    localparam logic [2:0] CH_BATT  = 3'd5;
    localparam logic [2:0] CH_STEER = 3'd3;

    // Conversion sequencer states
    typedef enum logic [1:0] {
        IDLE,
        CNV,
        GAP,
        READ
    } a2d_state_t;

    // Command word that selects a channel for the following transaction
    function automatic logic [15:0] cnv_cmd(input logic [2:0] ch);
        return {2'b00, ch, 11'h000};
    endfunction

endpackage

// File: rtl/spi_mstr16.sv
// -----------------------------------------------------------------------------
// spi_mstr16
// 16-bit SPI master, MSB first, SCLK = clk/32 idling high. MOSI changes on
// SCLK falling edges; MISO is captured one clk before each SCLK rising edge.
// A transaction lasts 521 clk from SS_n falling to SS_n rising.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   wrt      in   start a transaction with cmd (ignored while busy)
//   cmd      in   16-bit word to shift out
//   MISO     in   serial data from the slave
//   done     out  one-clk pulse when the transaction has finished
//   rd_data  out  16-bit word received during the last transaction
//   SS_n     out  active-low slave select
//   SCLK     out  serial clock
//   MOSI     out  serial data to the slave
// -----------------------------------------------------------------------------
module spi_mstr16
    import a2d_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] cmd,
    input  logic        MISO,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI
);

    // The divider starts part way through the high phase so SS_n leads the
    // first SCLK fall by 9 clk; 11111 is the clk before a fall and 01111 the
    // clk before a rise.
    localparam logic [SCLK_DIV_W-1:0] DIV_START = 5'b10111;
    localparam logic [SCLK_DIV_W-1:0] DIV_LAST  = '1;
    localparam logic [SCLK_DIV_W-1:0] DIV_SMPL  = {1'b0, {(SCLK_DIV_W-1){1'b1}}};

    logic                  busy;
    logic [SCLK_DIV_W-1:0] sclk_div;
    logic [4:0]            bit_cnt;
    logic [15:0]           tx_shft;
    logic [15:0]           rx_shft;
    logic                  smpl;
    logic                  shft;
    logic                  finish;

    assign smpl   = busy && (sclk_div == DIV_SMPL);
    // The first SCLK fall must not shift: bit 15 is already on MOSI.
    assign shft   = busy && (sclk_div == DIV_LAST) && (bit_cnt != 5'd0) && (bit_cnt != 5'd16);
    // After the 16th sample, end where the next fall would have been so
    // SCLK never drops again.
    assign finish = busy && (sclk_div == DIV_LAST) && (bit_cnt == 5'd16);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            sclk_div <= DIV_START;
            bit_cnt  <= 5'd0;
            tx_shft  <= 16'h0000;
            rx_shft  <= 16'h0000;
            SS_n     <= 1'b1;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (wrt) begin
                    busy     <= 1'b1;
                    SS_n     <= 1'b0;
                    sclk_div <= DIV_START;
                    bit_cnt  <= 5'd0;
                    tx_shft  <= cmd;
                end
            end else if (finish) begin
                busy     <= 1'b0;
                SS_n     <= 1'b1;
                done     <= 1'b1;
                tx_shft  <= 16'h0000;
                sclk_div <= DIV_START;
            end else begin
                sclk_div <= sclk_div + 1'b1;
                if (smpl) begin
                    rx_shft <= {rx_shft[14:0], MISO};
                    bit_cnt <= bit_cnt + 5'd1;
                end
                if (shft) begin
                    tx_shft <= {tx_shft[14:0], 1'b0};
                end
            end
        end
    end

    assign SCLK    = sclk_div[SCLK_DIV_W-1];
    assign MOSI    = tx_shft[15];
    assign rd_data = rx_shft;

endmodule

// File: rtl/a2d_intf.sv
// -----------------------------------------------------------------------------
// a2d_intf
// Sequences conversions on an ADC128S. Each nxt pulse (accepted only while
// idle) converts the next channel in round-robin order 0, 4, 5 (then 3 when
// the steering pot is enabled). A conversion is a channel-select transaction
// followed, after a 2-clk gap, by a read transaction whose low 12 bits are
// stored in that channel's result register.
//
// Build option:
//   A2D_STEER_POT_EN  adds the steer_pot output (channel 3) to the rotation.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   nxt        in   one-clk request to convert the next channel
//   lft_ld     out  left load cell reading (channel 0)
//   rght_ld    out  right load cell reading (channel 4)
//   batt       out  battery reading (channel 5)
//   steer_pot  out  steering pot reading (channel 3, optional)
//   SS_n       out  SPI select to the ADC
//   SCLK       out  SPI clock to the ADC
//   MOSI       out  SPI data to the ADC
//   MISO       in   SPI data from the ADC
// -----------------------------------------------------------------------------
module a2d_intf
    import a2d_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
`ifdef A2D_STEER_POT_EN
    output logic [11:0] steer_pot,
`endif
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

`ifdef A2D_STEER_POT_EN
    localparam logic [1:0] LAST_IDX = 2'd3;
`else
    localparam logic [1:0] LAST_IDX = 2'd2;
`endif

    a2d_state_t  state;
    a2d_state_t  nxt_state;
    logic        gap_cnt;
    logic [1:0]  rr_idx;
    logic [2:0]  cur_ch;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rd_data;
    logic        wr_result;
    logic        unused_msbs;

    // The ADC returns four leading bits that carry no data.
    assign unused_msbs = ^rd_data[15:12];

    spi_mstr16 u_spi (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (wrt),
        .cmd     (cmd),
        .MISO    (MISO),
        .done    (done),
        .rd_data (rd_data),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI)
    );

    // Round-robin position to ADC channel
    always_comb begin
        cur_ch = CH_LFT;
        case (rr_idx)
            2'd0:    cur_ch = CH_LFT;
            2'd1:    cur_ch = CH_RGHT;
            2'd2:    cur_ch = CH_BATT;
`ifdef A2D_STEER_POT_EN
            2'd3:    cur_ch = CH_STEER;
`endif
            default: cur_ch = CH_LFT;
        endcase
    end

    // State register; gap_cnt is high only on the second clk spent in GAP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gap_cnt <= 1'b0;
        end else begin
            state   <= nxt_state;
            gap_cnt <= (state == GAP) && !gap_cnt;
        end
    end

    // Next state and SPI requests
    always_comb begin
        nxt_state = state;
        wrt       = 1'b0;
        cmd       = 16'h0000;
        wr_result = 1'b0;
        case (state)
            IDLE: begin
                if (nxt) begin
                    wrt       = 1'b1;
                    cmd       = cnv_cmd(cur_ch);
                    nxt_state = CNV;
                end
            end
            CNV: begin
                if (done) begin
                    nxt_state = GAP;
                end
            end
            GAP: begin
                if (gap_cnt) begin
                    wrt       = 1'b1;
                    nxt_state = READ;
                end
            end
            READ: begin
                if (done) begin
                    wr_result = 1'b1;
                    nxt_state = IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    // Result registers and round-robin index, updated together at the end
    // of the read transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_idx    <= 2'd0;
            lft_ld    <= 12'h000;
            rght_ld   <= 12'h000;
            batt      <= 12'h000;
`ifdef A2D_STEER_POT_EN
            steer_pot <= 12'h000;
`endif
        end else if (wr_result) begin
            case (cur_ch)
                CH_LFT:   lft_ld    <= rd_data[11:0];
                CH_RGHT:  rght_ld   <= rd_data[11:0];
                CH_BATT:  batt      <= rd_data[11:0];
`ifdef A2D_STEER_POT_EN
                CH_STEER: steer_pot <= rd_data[11:0];
`endif
                default:  ;
            endcase
            rr_idx <= (rr_idx == LAST_IDX) ? 2'd0 : rr_idx + 2'd1;
        end
    end

endmodule

// File: tb/tb_a2d_intf.sv
// -----------------------------------------------------------------------------
// tb_a2d_intf
// Bench for a2d_intf with a behavioural ADC128S model. Each accepted nxt pushes
// the expected command word and result registers into a queue; the monitor
// decodes the SPI bus, drives MISO from the ADC model and pops/compares when a
// conversion's read transaction finishes. Define A2D_STEER_POT_EN to include
// the steering pot channel.
// -----------------------------------------------------------------------------
module tb_a2d_intf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        nxt;
    logic        MISO = 1'b0;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic [11:0] batt;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
`ifdef A2D_STEER_POT_EN
    logic [11:0] steer_pot;
    localparam int NUM_CH = 4;
`else
    localparam int NUM_CH = 3;
`endif

    always #5 clk = ~clk;

    a2d_intf dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .nxt       (nxt),
`ifdef A2D_STEER_POT_EN
        .steer_pot (steer_pot),
`endif
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .batt      (batt),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    typedef struct {
        logic [15:0] cmd;
        logic [11:0] lft;
        logic [11:0] rght;
        logic [11:0] batt;
        logic [11:0] steer;
    } exp_t;

    exp_t        sb_q[$];
    int          chk_cnt = 0;
    int          pass_cnt = 0;

    // Reference model: analogue value per ADC channel, expected register per
    // channel, and the rotation through the channel list
    logic [11:0] adc_val [8];
    logic [11:0] exp_reg [8];
    int          order [4] = '{0, 4, 5, 3};
    int          rr_pos = 0;

    // Monitor / ADC model state
    logic        prev_ss = 1'b1;
    logic        prev_sclk = 1'b1;
    int          low_cnt = 0;
    int          hi_cnt = 100;
    int          miso_idx = 0;
    logic [15:0] mosi_sr = 16'h0;
    logic [15:0] resp_word = 16'h0;
    logic [15:0] words [2];
    logic [2:0]  adc_ch;
    int          tr_in_conv = 0;
    int          check_delay = 0;
    int          conv_done_cnt = 0;
    int          activity_cnt = 0;
    bit          in_read = 1'b0;
    exp_t        mon_e;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One nxt pulse; when a conversion is expected, predict its outcome first
    task automatic applyStimulus(input bit expect_conv);
        exp_t e;
        int   ch;
        if (expect_conv) begin
            ch          = order[rr_pos];
            exp_reg[ch] = adc_val[ch];
            e.cmd       = 16'(ch * 2048);
            e.lft       = exp_reg[0];
            e.rght      = exp_reg[4];
            e.batt      = exp_reg[5];
            e.steer     = exp_reg[3];
            rr_pos      = (rr_pos + 1) % NUM_CH;
            sb_q.push_back(e);
        end
        @(negedge clk) nxt = 1'b1;
        @(negedge clk) nxt = 1'b0;
    endtask

    task automatic waitConv(input int target, input string name);
        int n = 0;
        while (conv_done_cnt < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, conv_done_cnt >= target, 1);
    endtask

    task automatic resetModel();
        rr_pos = 0;
        for (int i = 0; i < 8; i++) exp_reg[i] = 12'h000;
    endtask

    // SPI monitor, ADC128S model and scoreboard checker
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ss     = 1'b1;
            prev_sclk   = 1'b1;
            hi_cnt      = 100;
            tr_in_conv  = 0;
            check_delay = 0;
            in_read     = 1'b0;
            MISO        = 1'b0;
            sb_q.delete();
        end else begin
            if (SS_n !== 1'b1 || SCLK !== 1'b1) activity_cnt++;
            if (prev_ss && !SS_n) begin
                checkOutput("ss_high_gap", hi_cnt >= 2, 1);
                low_cnt  = 0;
                mosi_sr  = 16'h0;
                miso_idx = 15;
                in_read  = (tr_in_conv == 1);
            end
            if (!SS_n) begin
                low_cnt++;
                if (prev_sclk && !SCLK && miso_idx >= 0) begin
                    MISO = resp_word[miso_idx];
                    miso_idx--;
                end
                if (!prev_sclk && SCLK) mosi_sr = {mosi_sr[14:0], MOSI};
            end else begin
                hi_cnt++;
            end
            if (!prev_ss && SS_n) begin
                checkOutput("spi_len_in_range", low_cnt >= 512 && low_cnt <= 544, 1);
                hi_cnt    = 1;
                adc_ch    = mosi_sr[13:11];
                resp_word = {4'($urandom), adc_val[adc_ch]};
                words[tr_in_conv] = mosi_sr;
                in_read   = 1'b0;
                if (tr_in_conv == 0) begin
                    tr_in_conv = 1;
                end else begin
                    tr_in_conv  = 0;
                    check_delay = 4;
                end
            end
            if (check_delay > 0) begin
                check_delay--;
                if (check_delay == 0) begin
                    conv_done_cnt++;
                    checkOutput("sb_has_entry", sb_q.size() > 0, 1);
                    if (sb_q.size() > 0) begin
                        mon_e = sb_q.pop_front();
                        checkOutput("cnv_cmd_word", words[0], mon_e.cmd);
                        checkOutput("read_cmd_word", words[1], 16'h0000);
                        checkOutput("lft_ld", lft_ld, mon_e.lft);
                        checkOutput("rght_ld", rght_ld, mon_e.rght);
                        checkOutput("batt", batt, mon_e.batt);
`ifdef A2D_STEER_POT_EN
                        checkOutput("steer_pot", steer_pot, mon_e.steer);
`endif
                    end
                end
            end
            prev_ss   = SS_n;
            prev_sclk = SCLK;
        end
    end

    initial begin
        int act0;
        int base;
        int n;
        rst_n = 1'b0;
        nxt   = 1'b0;
        for (int i = 0; i < 8; i++) adc_val[i] = 12'(i * 291);
        resetModel();
        repeat (3) @(negedge clk);
        checkOutput("rst_SS_n", SS_n, 1'b1);
        checkOutput("rst_SCLK", SCLK, 1'b1);
        checkOutput("rst_MOSI", MOSI, 1'b0);
        checkOutput("rst_lft_ld", lft_ld, 12'h000);
        checkOutput("rst_rght_ld", rght_ld, 12'h000);
        checkOutput("rst_batt", batt, 12'h000);
        @(negedge clk) rst_n = 1'b1;

        // No requests: bus stays idle and results stay cleared
        act0 = activity_cnt;
        repeat (2000) @(negedge clk);
        checkOutput("idle_no_spi", activity_cnt - act0, 0);
        checkOutput("idle_lft_ld", lft_ld, 12'h000);
        checkOutput("idle_rght_ld", rght_ld, 12'h000);
        checkOutput("idle_batt", batt, 12'h000);

        // Directed values through one full rotation plus one
        adc_val[0] = 12'h108;
        adc_val[4] = 12'h180;
        adc_val[5] = 12'hD40;
        adc_val[3] = 12'h5A7;
        for (int i = 0; i < NUM_CH + 1; i++) begin
            base = conv_done_cnt;
            applyStimulus(1'b1);
            repeat (1500) @(negedge clk);
            waitConv(base + 1, "directed_conv_done");
        end

        // Extra requests during a conversion are ignored
        base = conv_done_cnt;
        adc_val[order[rr_pos]] = 12'($urandom);
        applyStimulus(1'b1);
        for (int i = 0; i < 90; i++) begin
            repeat (8) @(negedge clk);
            applyStimulus(1'b0);
        end
        waitConv(base + 1, "spam_conv_done");
        repeat (100) @(negedge clk);
        checkOutput("spam_single_conv", conv_done_cnt, base + 1);
        checkOutput("spam_bus_idle", SS_n, 1'b1);

        // Randomised conversions
        for (int i = 0; i < 8; i++) begin
            adc_val[0] = 12'($urandom);
            adc_val[3] = 12'($urandom);
            adc_val[4] = 12'($urandom);
            adc_val[5] = 12'($urandom);
            base = conv_done_cnt;
            applyStimulus(1'b1);
            waitConv(base + 1, "rand_conv_done");
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end

        // Reset in the middle of a read transaction
        applyStimulus(1'b1);
        n = 0;
        while (!in_read && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("read_phase_reached", in_read, 1'b1);
        repeat (200) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_SS_n", SS_n, 1'b1);
        checkOutput("midrst_SCLK", SCLK, 1'b1);
        checkOutput("midrst_MOSI", MOSI, 1'b0);
        checkOutput("midrst_lft_ld", lft_ld, 12'h000);
        checkOutput("midrst_rght_ld", rght_ld, 12'h000);
        checkOutput("midrst_batt", batt, 12'h000);
        sb_q.delete();
        resetModel();
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        adc_val[0] = 12'hA5C;
        base = conv_done_cnt;
        applyStimulus(1'b1);
        waitConv(base + 1, "post_rst_conv_done");

        repeat (20) @(negedge clk);
        checkOutput("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/a2d_intf.md
A2D_INTF -- requirements
Module: a2d_intf

Interface
REQ-001 The block SHALL have a clk input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-002 The block SHALL have an rst_n input, 1 bit, asynchronous active-low reset.
REQ-003 The block SHALL have an nxt input, 1 bit; a single-clk pulse requests one conversion of the next channel in round-robin order.
REQ-004 The block SHALL have an lft_ld output, 12 bits, holding the latest left load cell reading (ADC channel 0).
REQ-005 The block SHALL have an rght_ld output, 12 bits, holding the latest right load cell reading (ADC channel 4).
REQ-006 The block SHALL have a batt output, 12 bits, holding the latest battery reading (ADC channel 5).
REQ-007 The block SHALL have an SS_n output, 1 bit, the active-low SPI select to the ADC128S.
REQ-008 The block SHALL have an SCLK output, 1 bit, the SPI clock to the ADC128S.
REQ-009 The block SHALL have a MOSI output, 1 bit, the SPI data to the ADC128S.
REQ-010 The block SHALL have a MISO input, 1 bit, the SPI data from the ADC128S.

Function
REQ-011 SPI transactions SHALL use the following format:
- 16 bits, MSB first.
- SCLK = clk/32, idle high.
- MOSI changes on the SCLK falling edge.
- MISO is sampled on the clk in which the divider is one count before the SCLK rising edge.
REQ-012 Each transaction SHALL meet these timing rules:
- Duration is 512..544 clk from SS_n falling to SS_n rising.
- SS_n is high for at least 2 clk between transactions.
REQ-013 Each conversion SHALL consist of two back-to-back transactions:
- First: MOSI word {2'b00, ch[2:0], 11'h000}; the received data is discarded.
- Second: MOSI word all zeros; the result is the received word's bits [11:0].
REQ-014 The FSM SHALL have four states: IDLE, CNV, GAP, READ.
- IDLE->CNV on nxt.
- CNV->GAP on transaction done.
- GAP->READ after 2 clk.
- READ->IDLE on transaction done.
REQ-015 In READ->IDLE the result SHALL be written into the register for the current channel and the round-robin index advanced, both in the same clk.
REQ-016 The round-robin order SHALL be 0, 4, 5, then wrap to 0.
REQ-017 nxt asserted outside IDLE SHALL be ignored; requests are neither queued nor counted.
REQ-018 Results not currently being written SHALL hold their values; a register updates only on completion of its own channel.
REQ-019 Results SHALL be unsigned 12-bit with no scaling; MISO bits [15:12] are dropped.

Reset
REQ-020 While rst_n=0, all state SHALL take reset values asynchronously, including mid-transaction:
- FSM IDLE; index 0.
- SS_n=1, SCLK=1, MOSI=0.
- lft_ld=rght_ld=batt=12'h000.
REQ-021 After reset release, no SPI activity SHALL occur until the first nxt.

Configuration
REQ-022 Macro A2D_STEER_POT_EN controls a steering potentiometer channel.
- Defined: output steer_pot[11:0] (ADC channel 3, reset 12'h000) is added; order becomes 0, 4, 5, 3, then wrap.
- Undefined: the port and channel 3 are absent; behaviour is exactly REQ-016.

Structure
REQ-023 A shared package a2d_pkg SHALL hold:
- Channel constants CH_LFT=3'd0, CH_RGHT=3'd4, CH_BATT=3'd5, CH_STEER=3'd3.
- The FSM state enum.
- SCLK_DIV_W=5.
REQ-024 SPI serialization SHALL live in sub-module spi_mstr16 with this interface:
- Inputs: clk, rst_n, wrt, cmd[15:0], MISO.
- Outputs: done (1-clk pulse), rd_data[15:0], SS_n, SCLK, MOSI.
REQ-025 a2d_intf SHALL contain only sequencing and result registers.

Verification
REQ-026 Bench against the ADC128S model. Directed scenarios:
- Reset, then 2000 clk with no nxt -> SS_n stays 1, SCLK stays 1, all outputs 12'h000.
- Set lft_cell_set=12'h108, one nxt -> MOSI first word 16'h0000; after READ, lft_ld=12'h108; rght_ld and batt unchanged.
- Set rght_cell_set=12'h180 and batt_set=12'hD40, three nxt spaced 1500 clk -> MOSI words 16'h0000, 16'h2000, 16'h2800 in order; lft_ld, rght_ld=12'h180, batt=12'hD40; fourth nxt reads channel 0 again.
- nxt pulsed every 10 clk during a conversion -> exactly one conversion completes; extra pulses ignored.
- rst_n low midway through the READ transaction -> SS_n=1, SCLK=1, outputs 12'h000 immediately; next nxt converts channel 0.
- A2D_STEER_POT_EN defined, four nxt -> fourth MOSI command 16'h1800; steer_pot = model channel-3 value.
